hex_key_event_queue: RTL and testbench
======================================

# hex_key_event_queue

Downstream stage of the hex keypad encoder. Consumes the encoder's `Code`/`Valid` outputs and filters out repeated `Valid` pulses caused by contact bounce or re-scans of the same held key, using a retriggerable hold-off window. Each accepted key press is turned into exactly one 4-bit event. Events are buffered in a small show-ahead FIFO and presented to the consumer (CPU register, display driver) over a valid/ready handshake, with a sticky overflow flag.

## Interface
- `HOLDOFF`, default 16'd1000: number of consecutive `Valid`-low cycles that close the hold-off window. Legal range 1..65535.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2, at least 2.
- `clock`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `Code`  input  4  key code from the encoder; meaningful only when `Valid`=1.
- `Valid`  input  1  encoder key-detected strobe; sampled every rising edge.
- `Key_Ready`  input  1  consumer accepts the head event this cycle.
- `Clear`  input  1  synchronous clear of `Overflow`.
- `Key_Data`  output  4  head-of-queue key code.
- `Key_Valid`  output  1  queue not empty; `Key_Data` is valid.
- `Count`  output  log2(DEPTH)+1  number of queued events.
- `Overflow`  output  1  sticky: an accepted event was dropped because the queue was full.
- `Busy`  output  1  hold-off window active (FSM in LOCKOUT).

## Operation
- **Reset values** (while `reset`=0): FSM=IDLE, hold-off timer=0, last-code=0, FIFO pointers=0, `Key_Valid`=0, `Key_Data`=0, `Count`=0, `Overflow`=0, `Busy`=0.
- **FSM states:** IDLE and LOCKOUT.
  - IDLE, `Valid`=1: raise an accept event with `Code`, set last-code to `Code`, load timer with `HOLDOFF`, go to LOCKOUT.
  - IDLE, `Valid`=0: stay in IDLE.
  - LOCKOUT, `Valid`=1 and `Code`=last-code: reload timer with `HOLDOFF`. No event.
  - LOCKOUT, `Valid`=1 and `Code`≠last-code: raise an accept event with `Code`, update last-code, reload timer. Stay in LOCKOUT.
  - LOCKOUT, `Valid`=0: decrement timer. When the timer is 1, go to IDLE instead (timer becomes 0). LOCKOUT therefore exits on the `HOLDOFF`-th consecutive `Valid`-low sample.
- **FIFO push:** an accept event pushes `Code` if `Count`<`DEPTH`, or if `Count`=`DEPTH` and a pop occurs in the same cycle.
  - Otherwise the event is dropped and `Overflow` is set.
  - The FSM transitions happen whether or not the push succeeds.
- **FIFO pop:** occurs when `Key_Valid`=1 and `Key_Ready`=1. `Key_Ready` with an empty queue is ignored.
- **Simultaneous push and pop:** `Count` is unchanged and both pointers advance.
- **Pointers:** wrap modulo `DEPTH`.
- **Show-ahead output:** `Key_Data` = entry at the read pointer. When the queue is empty, `Key_Data` holds the last value and has no meaning.
- **Overflow and Clear:** `Clear` zeroes `Overflow`. If a drop and `Clear` happen in the same cycle, set wins.
- **Asynchronous reset mid-operation:** FIFO contents are discarded and all outputs return to their reset values immediately. Operation resumes on the first edge after `reset` deasserts.

## Timing
- **Latency:** `Valid` sampled high at edge N (accepted, queue empty) gives `Key_Valid`=1 and `Key_Data`=`Code` after edge N. That is one cycle, with no combinational path from inputs to outputs.
- **Pop:** a pop at edge M updates `Key_Data`/`Key_Valid`/`Count` after edge M. Back-to-back pops are allowed every cycle.
- **Busy:** `Busy` rises after the accepting edge. It falls after the edge that samples the `HOLDOFF`-th consecutive `Valid`=0.
- **Minimum re-acceptance gap:** the same code is accepted again at the earliest `HOLDOFF`+1 cycles after its last `Valid` pulse.
- **Throughput:** one accept per cycle is possible when codes alternate.

## Test plan
- **Single press, then release:** after reset (`HOLDOFF`=4), `Valid`=1 with `Code`=4'hA for 1 cycle, then 0.
  - Required: `Key_Valid`=1 and `Key_Data`=A one cycle later, `Count`=1.
  - Required: `Busy` is high for exactly 4 cycles after the pulse.
- **Bounce suppression:** `Code`=5 pulses at cycles 0, 2, 5, 8 (gaps under 4).
  - Required: exactly one event (5) is queued.
  - Required: a further pulse at cycle 13 (4 low cycles after cycle 8) queues a second 5.
- **Code change inside the window:** `Code`=3 at cycle 0, `Code`=7 at cycle 1.
  - Required: the queue holds 3 then 7, and `Count`=2.
- **Overflow, then Clear:** with `Key_Ready`=0, queue 5 distinct codes 0..4 (`DEPTH`=4).
  - Required: `Count`=4 and `Overflow`=1.
  - Required: draining yields 0, 1, 2, 3.
  - Required: `Clear` pulse sets `Overflow`=0. `Clear` in the same cycle as a drop leaves `Overflow`=1.
- **Full plus simultaneous push/pop:** queue full, `Key_Ready`=1 on the same edge as a new accept of code F.
  - Required: `Count` stays 4, no overflow, and F is the last entry drained.
- **Asynchronous reset mid-operation:** assert `reset`=0 between clock edges while `Count`=2 and `Busy`=1.
  - Required: `Count`, `Key_Valid`, `Busy` and `Overflow` read 0 immediately, before the next edge.
  - Required: a new press after release of reset is accepted with 1-cycle latency.

Source files
------------

// File: rtl/hex_key_event_queue.sv
// Key event queue behind the hex keypad encoder: suppresses bounce/re-scan repeats
// with a retriggerable hold-off window and buffers accepted codes in a show-ahead FIFO.
module hex_key_event_queue #(
   parameter logic [15:0] HOLDOFF = 16'd1000,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [3:0]               Code,
   input  logic                     Valid,
   input  logic                     Key_Ready,
   input  logic                     Clear,
   output logic [3:0]               Key_Data,
   output logic                     Key_Valid,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Overflow,
   output logic                     Busy,
   output logic                     dbg_state_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   typedef enum logic {
      IDLE    = 1'b0,
      LOCKOUT = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [15:0]     timer_q, timer_d;
   logic [3:0]      last_q, last_d;
   logic [3:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            ovf_q, ovf_d;

   logic            accept;
   logic            push;
   logic            pop;
   logic            drop;

   // Consumer handshake: Key_Valid means Key_Data holds the head event; the head is
   // consumed on a rising edge where Key_Valid and Key_Ready are both 1, and
   // Key_Ready while Key_Valid is 0 has no effect.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      last_d  = last_q;
      accept  = 1'b0;

      case (state_q)
         IDLE: begin
            if (Valid) begin
               accept  = 1'b1;
               last_d  = Code;
               timer_d = HOLDOFF;
               state_d = LOCKOUT;
            end
         end
         LOCKOUT: begin
            if (Valid) begin
               timer_d = HOLDOFF;
               if (Code != last_q) begin
                  accept = 1'b1;
                  last_d = Code;
               end
            end else if (timer_q == 16'd1) begin
               timer_d = 16'd0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = 16'd0;
         end
      endcase
   end

   // A full queue still takes a new event when the head leaves on the same edge.
   always_comb begin
      pop      = (count_q != '0) && Key_Ready;
      push     = accept && ((count_q < FULL_C) || pop);
      drop     = accept && !push;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + {{AW{1'b0}}, 1'b1};
      end else if (pop && !push) begin
         count_d = count_q - {{AW{1'b0}}, 1'b1};
      end
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (Clear) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         timer_q  <= 16'd0;
         last_q   <= 4'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         last_q   <= last_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is cleared on reset so Key_Data reads 0 until the first push.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= 4'd0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= Code;
      end
   end

   assign Key_Data    = mem_q[rd_ptr_q];
   assign Key_Valid   = (count_q != '0);
   assign Count       = count_q;
   assign Overflow    = ovf_q;
   assign Busy        = (state_q == LOCKOUT);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hex_key_event_queue.sv
// Directed bench for hex_key_event_queue (HOLDOFF=4, DEPTH=4) with an expected-code
// queue filled when an accepting press is driven and drained when events are popped.
module tb_hex_key_event_queue;

   logic       clock;
   logic       reset;
   logic [3:0] Code;
   logic       Valid;
   logic       Key_Ready;
   logic       Clear;
   logic [3:0] Key_Data;
   logic       Key_Valid;
   logic [2:0] Count;
   logic       Overflow;
   logic       Busy;
   logic       dbg_state;

   int checks   = 0;
   int failures = 0;
   logic [3:0] exp_q[$];

   hex_key_event_queue #(
      .HOLDOFF (16'd4),
      .DEPTH   (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .Code        (Code),
      .Valid       (Valid),
      .Key_Ready   (Key_Ready),
      .Clear       (Clear),
      .Key_Data    (Key_Data),
      .Key_Valid   (Key_Valid),
      .Count       (Count),
      .Overflow    (Overflow),
      .Busy        (Busy),
      .dbg_state_o (dbg_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one sampled edge with the given Valid/Code, then settle past the edge.
   task automatic cyc(input logic v, input logic [3:0] c);
      Valid = v;
      Code  = c;
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [3:0] c);
      exp_q.push_back(c);
      cyc(1'b1, c);
   endtask

   task automatic check_count(input string tag);
      chk(tag, 32'(Count), 32'(exp_q.size()));
   endtask

   // Pop one event through the handshake and compare it against the scoreboard.
   task automatic pop_check(input string tag);
      logic [3:0] exp_code;
      chk({tag, "_kv"}, 32'(Key_Valid), 32'd1);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s_empty_sb observed=%0h expected=none", tag, Key_Data);
      end else begin
         exp_code = exp_q.pop_front();
         chk({tag, "_data"}, 32'(Key_Data), 32'(exp_code));
      end
      Key_Ready = 1'b1;
      cyc(1'b0, 4'd0);
      Key_Ready = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0);
      chk("idle_busy", 32'(Busy), 32'd0);
   endtask

   initial begin
      reset     = 1'b0;
      Code      = 4'd0;
      Valid     = 1'b0;
      Key_Ready = 1'b0;
      Clear     = 1'b0;
      #12;
      chk("rst_count", 32'(Count), 32'd0);
      chk("rst_kv", 32'(Key_Valid), 32'd0);
      chk("rst_data", 32'(Key_Data), 32'd0);
      chk("rst_ovf", 32'(Overflow), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // Single press, then release: Busy spans exactly 4 cycles.
      press(4'hA);
      chk("single_kv", 32'(Key_Valid), 32'd1);
      chk("single_data", 32'(Key_Data), 32'hA);
      check_count("single_count");
      chk("single_busy0", 32'(Busy), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 4'd0);
         chk($sformatf("single_busy%0d", i), 32'(Busy), (i < 4) ? 32'd1 : 32'd0);
      end
      pop_check("single_pop");
      chk("single_empty", 32'(Key_Valid), 32'd0);

      // Bounce suppression: pulses at 0,2,5,8 give one event; 13 gives another.
      for (int c = 0; c <= 13; c++) begin
         if (c == 0 || c == 13) press(4'h5);
         else cyc((c == 2 || c == 5 || c == 8), 4'h5);
         if (c == 12) check_count("bounce_count1");
      end
      check_count("bounce_count2");
      wait_idle();
      pop_check("bounce_pop1");
      pop_check("bounce_pop2");

      // Code change inside the window.
      press(4'h3);
      press(4'h7);
      check_count("change_count");
      chk("change_count2", 32'(Count), 32'd2);
      wait_idle();
      pop_check("change_pop1");
      pop_check("change_pop2");

      // Overflow, Clear-vs-drop priority, plain Clear, then drain.
      for (int k = 0; k < 4; k++) press(4'(k));
      cyc(1'b1, 4'd4);
      chk("ovf_count", 32'(Count), 32'd4);
      chk("ovf_set", 32'(Overflow), 32'd1);
      Clear = 1'b1;
      cyc(1'b1, 4'd5);
      chk("ovf_clear_vs_drop", 32'(Overflow), 32'd1);
      cyc(1'b0, 4'd0);
      Clear = 1'b0;
      chk("ovf_cleared", 32'(Overflow), 32'd0);
      for (int k = 0; k < 4; k++) pop_check($sformatf("ovf_pop%0d", k));
      check_count("ovf_drained");

      // Full queue with a simultaneous pop and accept of F.
      wait_idle();
      press(4'h8);
      press(4'h9);
      press(4'hA);
      press(4'hB);
      chk("full_count", 32'(Count), 32'd4);
      chk("full_head", 32'(Key_Data), 32'(exp_q.pop_front()));
      Key_Ready = 1'b1;
      press(4'hF);
      Key_Ready = 1'b0;
      chk("full_pp_count", 32'(Count), 32'd4);
      chk("full_pp_ovf", 32'(Overflow), 32'd0);
      wait_idle();
      for (int k = 0; k < 4; k++) pop_check($sformatf("full_pop%0d", k));
      check_count("full_drained");

      // Asynchronous reset mid-operation.
      press(4'h1);
      press(4'h2);
      chk("arst_pre_count", 32'(Count), 32'd2);
      chk("arst_pre_busy", 32'(Busy), 32'd1);
      Valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      exp_q.delete();
      chk("arst_count", 32'(Count), 32'd0);
      chk("arst_kv", 32'(Key_Valid), 32'd0);
      chk("arst_busy", 32'(Busy), 32'd0);
      chk("arst_ovf", 32'(Overflow), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      press(4'h6);
      chk("arst_new_kv", 32'(Key_Valid), 32'd1);
      chk("arst_new_data", 32'(Key_Data), 32'h6);
      check_count("arst_new_count");
      pop_check("arst_pop");
      check_count("final_count");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
